// File: rtl/jelly3_axi4l_pwm_if.sv
// AXI4-Lite bus bundle shared by the jfive peripherals.
// Slave side uses modport s, master side uses modport m.
interface jelly3_axi4l_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
) (
  input logic aresetn,
  input logic aclk
);
  localparam int STRB_BITS = DATA_BITS / 8;

  logic [ADDR_BITS-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BITS-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport s (
    input  aresetn, aclk,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport m (
    input  aresetn, aclk,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/jelly3_axi4l_pwm.sv
// AXI4-Lite PWM generator with double-buffered period/duty.
// Define JELLY3_PWM_IRQ_EN to build the period-wrap interrupt flag.
module jelly3_axi4l_pwm #(
  parameter int                   CHANNELS    = 4,
  parameter int                   CNT_BITS    = 16,
  parameter int                   ADDR_BITS   = 32,
  parameter logic [CNT_BITS-1:0]  INIT_PERIOD = '1
) (
  input  logic                aresetn,
  input  logic                aclk,
  jelly3_axi4l_if.s           s_axi4l,
  output logic [CHANNELS-1:0] pwm,
  output logic                irq
);
  typedef logic [CNT_BITS-1:0] cnt_t;

  logic ctrl_en;
  cnt_t prescale;
  cnt_t period;
  cnt_t duty [CHANNELS];
  logic irq_flag;

  cnt_t pre_cnt;
  cnt_t cnt;
  cnt_t per_sh;
  cnt_t duty_sh [CHANNELS];
  logic run;

  cnt_t per_eff;
  cnt_t duty_eff [CHANNELS];
  logic tick;
  logic wrap;

  logic        wr_fire;
  logic [3:0]  wa;
  logic [3:0]  ra;
  logic [31:0] rd_word;
  logic        irq_clr;

  logic unused_bits;

  function automatic cnt_t merge(
    input cnt_t        old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] o;
    o = 32'(old);
    for (int b = 0; b < 4; b++)
      if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return cnt_t'(o);
  endfunction

  assign wr_fire = s_axi4l.awready
                 & s_axi4l.awvalid
                 & s_axi4l.wvalid;
  assign wa = s_axi4l.awaddr[5:2];
  assign ra = s_axi4l.araddr[5:2];
  assign irq_clr = wr_fire && wa == 4'h4
                 && s_axi4l.wstrb[0]
                 && s_axi4l.wdata[0];

  assign s_axi4l.bresp = 2'b00;
  assign s_axi4l.rresp = 2'b00;

  assign unused_bits = ^{
    s_axi4l.awaddr[ADDR_BITS-1:6],
    s_axi4l.awaddr[1:0],
    s_axi4l.araddr[ADDR_BITS-1:6],
    s_axi4l.araddr[1:0],
    s_axi4l.awprot, s_axi4l.arprot,
    s_axi4l.aclk, s_axi4l.aresetn,
    irq_clr
  };

  // Write handshake: one-cycle ready pulse, held off while B pending.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi4l.awready <= 1'b0;
      s_axi4l.wready  <= 1'b0;
      s_axi4l.bvalid  <= 1'b0;
    end else begin
      s_axi4l.awready <= s_axi4l.awvalid & s_axi4l.wvalid
                       & !s_axi4l.bvalid & !s_axi4l.awready;
      s_axi4l.wready  <= s_axi4l.awvalid & s_axi4l.wvalid
                       & !s_axi4l.bvalid & !s_axi4l.awready;
      if (wr_fire)
        s_axi4l.bvalid <= 1'b1;
      else if (s_axi4l.bready)
        s_axi4l.bvalid <= 1'b0;
    end
  end

  // Register file updates with per-byte strobes.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_en  <= 1'b0;
      prescale <= '0;
      period   <= INIT_PERIOD;
      for (int i = 0; i < CHANNELS; i++)
        duty[i] <= '0;
    end else if (wr_fire) begin
      case (wa)
        4'h0: if (s_axi4l.wstrb[0])
                ctrl_en <= s_axi4l.wdata[0];
        4'h1: prescale <= merge(prescale,
                s_axi4l.wdata, s_axi4l.wstrb);
        4'h2: period <= merge(period,
                s_axi4l.wdata, s_axi4l.wstrb);
        default: ;
      endcase
      for (int i = 0; i < CHANNELS; i++)
        if (wa == 4'(8 + i))
          duty[i] <= merge(duty[i],
            s_axi4l.wdata, s_axi4l.wstrb);
    end
  end

  // Read data mux; unmapped words read as zero.
  always_comb begin
    rd_word = '0;
    case (ra)
      4'h0: rd_word = {31'd0, ctrl_en};
      4'h1: rd_word = 32'(prescale);
      4'h2: rd_word = 32'(period);
      4'h3: rd_word = 32'(cnt);
      4'h4: rd_word = {31'd0, irq_flag};
      default: ;
    endcase
    for (int i = 0; i < CHANNELS; i++)
      if (ra == 4'(8 + i))
        rd_word = 32'(duty[i]);
  end

  // Read handshake: one-cycle arready, data one cycle later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi4l.arready <= 1'b0;
      s_axi4l.rvalid  <= 1'b0;
      s_axi4l.rdata   <= '0;
    end else begin
      s_axi4l.arready <= s_axi4l.arvalid
                       & !s_axi4l.rvalid & !s_axi4l.arready;
      if (s_axi4l.arready & s_axi4l.arvalid) begin
        s_axi4l.rvalid <= 1'b1;
        s_axi4l.rdata  <= rd_word;
      end else if (s_axi4l.rready) begin
        s_axi4l.rvalid <= 1'b0;
      end
    end
  end

  // First enabled cycle bypasses the shadows so new values apply at once.
  always_comb begin
    per_eff = run ? per_sh : period;
    for (int i = 0; i < CHANNELS; i++)
      duty_eff[i] = run ? duty_sh[i] : duty[i];
    tick = (pre_cnt >= prescale);
    wrap = ctrl_en & tick & (cnt == per_eff);
  end

  // Counter engine with shadow reload at wrap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run     <= 1'b0;
      pre_cnt <= '0;
      cnt     <= '0;
      per_sh  <= '0;
      pwm     <= '0;
      for (int i = 0; i < CHANNELS; i++)
        duty_sh[i] <= '0;
    end else if (!ctrl_en) begin
      run     <= 1'b0;
      pre_cnt <= '0;
      cnt     <= '0;
      pwm     <= '0;
    end else begin
      run <= 1'b1;
      if (!run || wrap) begin
        per_sh <= period;
        for (int i = 0; i < CHANNELS; i++)
          duty_sh[i] <= duty[i];
      end
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick)
        cnt <= (cnt == per_eff) ? '0 : cnt + 1'b1;
      for (int i = 0; i < CHANNELS; i++)
        pwm[i] <= (cnt < duty_eff[i]);
    end
  end

`ifdef JELLY3_PWM_IRQ_EN
  // Sticky wrap flag; a set in the same cycle beats a clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      irq_flag <= 1'b0;
    else if (wrap)
      irq_flag <= 1'b1;
    else if (irq_clr)
      irq_flag <= 1'b0;
  end
  assign irq = irq_flag;
`else
  assign irq_flag = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_jelly3_axi4l_pwm.sv
// Self-checking bench for jelly3_axi4l_pwm.
// Read expectations go through a scoreboard queue.
module tb_jelly3_axi4l_pwm;
  localparam int CH = 4;
  localparam int CB = 16;
`ifdef JELLY3_PWM_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CH-1:0] pwm;
  logic          irq;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  jelly3_axi4l_if #(.ADDR_BITS(32), .DATA_BITS(32)) axi (
    .aresetn(aresetn),
    .aclk   (aclk)
  );

  jelly3_axi4l_pwm #(
    .CHANNELS   (CH),
    .CNT_BITS   (CB),
    .ADDR_BITS  (32),
    .INIT_PERIOD('1)
  ) dut (
    .aresetn(aresetn),
    .aclk   (aclk),
    .s_axi4l(axi.s),
    .pwm    (pwm),
    .irq    (irq)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0]  s);
    int k;
    axi.awaddr  = a;
    axi.wdata   = d;
    axi.wstrb   = s;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    k = 0;
    step();
    while (!axi.awready && k < 20) begin
      step();
      k++;
    end
    n_run++;
    if (!(axi.awready && axi.wready)) begin
      n_fail++;
      $display("FAIL wr_accept a=%h awready=%b wready=%b want 1",
               a, axi.awready, axi.wready);
    end
    step();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    n_run++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_resp a=%h bvalid=%b bresp=%b want 1/00",
               a, axi.bvalid, axi.bresp);
    end
    step();
  endtask

  task automatic axi_read(input  logic [31:0] a,
                          input  logic [31:0] e,
                          output int          lat);
    int k;
    logic [31:0] want;
    exp_q.push_back(e);
    axi.araddr  = a;
    axi.arvalid = 1'b1;
    k = 1;
    step();
    while (!axi.arready && k < 20) begin
      step();
      k++;
    end
    lat = k;
    step();
    axi.arvalid = 1'b0;
    want = exp_q.pop_front();
    n_run++;
    if (axi.rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_valid a=%h rvalid=%b want 1", a, axi.rvalid);
    end else if (axi.rdata !== want || axi.rresp !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_data a=%h got=%h/%b want=%h/00",
               a, axi.rdata, axi.rresp, want);
    end
    step();
  endtask

  task automatic wait_rise(input string nm);
    logic prev;
    int   k;
    prev = pwm[0];
    step();
    k = 0;
    while (!(prev == 1'b0 && pwm[0] == 1'b1) && k < 200) begin
      prev = pwm[0];
      step();
      k++;
    end
    n_run++;
    if (pwm[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rise pwm0=%b want 1", nm, pwm[0]);
    end
  endtask

  task automatic count_runs(output int h1, output int l1,
                            output int h2, output int l2);
    h1 = 0; l1 = 0; h2 = 0; l2 = 0;
    while (pwm[0] && h1 < 100) begin h1++; step(); end
    while (!pwm[0] && l1 < 100) begin l1++; step(); end
    while (pwm[0] && h2 < 100) begin h2++; step(); end
    while (!pwm[0] && l2 < 100) begin l2++; step(); end
  endtask

  task automatic test_reset();
    int lat;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;
    repeat (3) step();
    n_run++;
    if ({axi.awready, axi.wready, axi.arready, axi.bvalid,
         axi.rvalid, pwm, irq} !== '0) begin
      n_fail++;
      $display("FAIL rst_out got=%b want 0",
               {axi.awready, axi.wready, axi.arready, axi.bvalid,
                axi.rvalid, pwm, irq});
    end
    aresetn = 1'b1;
    repeat (2) step();
    axi_read(32'h00, 32'h0, lat);
    axi_read(32'h04, 32'h0, lat);
    axi_read(32'h08, 32'h0000_FFFF, lat);
    axi_read(32'h0C, 32'h0, lat);
    axi_read(32'h10, 32'h0, lat);
    for (int i = 0; i < CH; i++)
      axi_read(32'h20 + 32'(4 * i), 32'h0, lat);
    axi_read(32'h14, 32'h0, lat);
    axi_read(32'h30, 32'h0, lat);
    n_run++;
    if (pwm !== '0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pwm pwm=%b irq=%b want 0", pwm, irq);
    end
  endtask

  task automatic test_wstrb();
    int lat;
    axi_write(32'h2C, 32'h1234_ABCD, 4'b0011);
    axi_read(32'h2C, 32'h0000_ABCD, lat);
    axi_write(32'h2C, 32'h0000_1100, 4'b0010);
    axi_read(32'h2C, 32'h0000_11CD, lat);
    axi_write(32'h2C, 32'h0000_FFFF, 4'b0000);
    axi_read(32'h2C, 32'h0000_11CD, lat);
    axi_write(32'h18, 32'hFFFF_FFFF, 4'b1111);
    axi_read(32'h18, 32'h0, lat);
    axi_write(32'h2C, 32'h0, 4'b1111);
  endtask

  task automatic test_pwm_basic();
    int h1, l1, h2, l2;
    axi_write(32'h04, 32'd1, 4'hF);
    axi_write(32'h08, 32'd9, 4'hF);
    axi_write(32'h20, 32'd3, 4'hF);
    axi_write(32'h00, 32'd1, 4'hF);
    wait_rise("basic");
    count_runs(h1, l1, h2, l2);
    n_run++;
    if (h1 != 6 || l1 != 14 || h2 != 6 || l2 != 14) begin
      n_fail++;
      $display("FAIL basic_runs got=%0d/%0d/%0d/%0d want 6/14/6/14",
               h1, l1, h2, l2);
    end
  endtask

  task automatic test_duty_extremes();
    int bad0, bad1;
    axi_write(32'h20, 32'd0, 4'hF);
    axi_write(32'h24, 32'd10, 4'hF);
    repeat (45) step();
    bad0 = 0; bad1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (pwm[0] !== 1'b0) bad0++;
      if (pwm[1] !== 1'b1) bad1++;
      step();
    end
    n_run++;
    if (bad0 != 0) begin
      n_fail++;
      $display("FAIL duty_zero high_cycles=%0d want 0", bad0);
    end
    n_run++;
    if (bad1 != 0) begin
      n_fail++;
      $display("FAIL duty_over low_cycles=%0d want 0", bad1);
    end
  endtask

  task automatic test_mid_update();
    int h1, l1, h2, l2, lat;
    axi_write(32'h20, 32'd3, 4'hF);
    repeat (45) step();
    wait_rise("mid");
    fork
      count_runs(h1, l1, h2, l2);
      begin
        step();
        step();
        axi_write(32'h20, 32'd7, 4'hF);
      end
    join
    n_run++;
    if (h1 != 6 || l1 != 14 || h2 != 14 || l2 != 6) begin
      n_fail++;
      $display("FAIL mid_runs got=%0d/%0d/%0d/%0d want 6/14/14/6",
               h1, l1, h2, l2);
    end
    axi_read(32'h20, 32'd7, lat);
  endtask

  task automatic test_back_to_back();
    int lat, bad, k;
    axi.bready = 1'b0;
    axi_write(32'h28, 32'h55, 4'hF);
    axi.awaddr  = 32'h28;
    axi.wdata   = 32'h66;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi_read(32'h28, 32'h55, lat);
    n_run++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL b2b_rd_lat got=%0d want 1", lat);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (axi.awready || axi.wready || !axi.bvalid) bad++;
      step();
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL b2b_hold bad_cycles=%0d want 0", bad);
    end
    axi.bready = 1'b1;
    k = 0;
    step();
    while (!axi.awready && k < 20) begin
      step();
      k++;
    end
    n_run++;
    if (axi.awready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept awready=%b want 1", axi.awready);
    end
    step();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    n_run++;
    if (axi.bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_bvalid got=%b want 1", axi.bvalid);
    end
    step();
    axi_read(32'h28, 32'h66, lat);
    axi_write(32'h28, 32'h0, 4'hF);
  endtask

  task automatic test_disable();
    int lat;
    axi_write(32'h00, 32'd0, 4'hF);
    step();
    n_run++;
    if (pwm !== '0) begin
      n_fail++;
      $display("FAIL dis_pwm got=%b want 0", pwm);
    end
    axi_read(32'h0C, 32'h0, lat);
  endtask

  task automatic test_irq();
    int lat, k, bad;
    axi_write(32'h10, 32'd1, 4'hF);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle got=%b want 0", irq);
    end
    axi_write(32'h04, 32'd0, 4'hF);
    axi_write(32'h08, 32'd0, 4'hF);
    axi_write(32'h00, 32'd1, 4'hF);
    k = 0;
    bad = 0;
    while (k < 10) begin
      if (irq !== IRQ_ON) bad++;
      step();
      k++;
    end
    n_run++;
    if (irq !== IRQ_ON || bad > 3) begin
      n_fail++;
      $display("FAIL irq_wrap got=%b want %b", irq, IRQ_ON);
    end
    axi_write(32'h10, 32'd1, 4'hF);
    n_run++;
    if (irq !== IRQ_ON) begin
      n_fail++;
      $display("FAIL irq_setwins got=%b want %b", irq, IRQ_ON);
    end
    axi_read(32'h10, {31'd0, IRQ_ON}, lat);
    axi_write(32'h00, 32'd0, 4'hF);
    repeat (3) step();
    axi_write(32'h10, 32'd1, 4'hF);
    n_run++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got=%b want 0", irq);
    end
    axi_read(32'h10, 32'h0, lat);
  endtask

  initial begin
    test_reset();
    test_wstrb();
    test_pwm_basic();
    test_duty_extremes();
    test_mid_update();
    test_back_to_back();
    test_disable();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
